// File: rtl/odo_nonce_feeder.sv
// Work source for the Odocrypt encrypt stage: walks a nonce range and emits one
// {nonce, header} word per nonce, paced to the downstream initiation interval.
module odo_nonce_feeder #(
    parameter int THROUGHPUT = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [607:0] header_in,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic         load,
    input  logic         pause,
    output logic [639:0] out,
    output logic         write,
    output logic         busy,
    output logic         done
);

    localparam logic [9:0] PACE_INIT = 10'(THROUGHPUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [607:0]   header_q, header_nx;
    logic [31:0]    nonce_q, nonce_nx;
    logic [31:0]    end_q, end_nx;
    logic [9:0]     pace_q, pace_nx;
    logic [639:0]   out_nx;
    logic           write_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            header_q <= '0;
            nonce_q  <= '0;
            end_q    <= '0;
            pace_q   <= '0;
            out      <= '0;
            write    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            header_q <= header_nx;
            nonce_q  <= nonce_nx;
            end_q    <= end_nx;
            pace_q   <= pace_nx;
            out      <= out_nx;
            write    <= write_nx;
            // Status flags follow the next state so they stay registered yet in step with write.
            busy     <= (state_nx == RUN);
            done     <= (state_nx == DONE);
        end
    end

    always_comb begin
        state_nx  = state;
        header_nx = header_q;
        nonce_nx  = nonce_q;
        end_nx    = end_q;
        pace_nx   = pace_q;
        out_nx    = out;
        write_nx  = 1'b0;

        if (load) begin
            header_nx = header_in;
            nonce_nx  = nonce_start;
            end_nx    = nonce_end;
            pace_nx   = '0;
            state_nx  = RUN;
        end else if (state == RUN) begin
            if (pace_q == '0 && !pause) begin
                write_nx = 1'b1;
                out_nx   = {nonce_q, header_q};
                pace_nx  = PACE_INIT;
                if (nonce_q == end_q)
                    state_nx = DONE;
                else
                    nonce_nx = nonce_q + 32'd1;
            end else if (pace_q != '0) begin
                // Pace keeps running under pause so a deferred word goes out as soon as pause drops.
                pace_nx = pace_q - 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_odo_nonce_feeder.sv
// Directed bench for odo_nonce_feeder: expected words and their arrival cycles are
// queued as stimulus is driven, then popped and compared whenever write strobes.
module tb_odo_nonce_feeder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [607:0] header_in = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic         load = 1'b0;
    logic         load1 = 1'b0;
    logic         pause = 1'b0;
    logic [639:0] out, out1;
    logic         write, write1, busy, busy1, done, done1;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    logic lq = 1'b0, lq1 = 1'b0;

    typedef struct {
        logic [639:0] word;
        int           at;
    } exp_t;

    exp_t q[$];
    exp_t q1[$];
    exp_t e, e1;

    odo_nonce_feeder #(.THROUGHPUT(10)) dut (
        .clk(clk), .reset(reset), .header_in(header_in), .nonce_start(nonce_start),
        .nonce_end(nonce_end), .load(load), .pause(pause),
        .out(out), .write(write), .busy(busy), .done(done)
    );

    odo_nonce_feeder #(.THROUGHPUT(1)) dut1 (
        .clk(clk), .reset(reset), .header_in(header_in), .nonce_start(nonce_start),
        .nonce_end(nonce_end), .load(load1), .pause(pause),
        .out(out1), .write(write1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        lq  <= load;
        lq1 <= load1;
    end

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [639:0] w(input logic [31:0] n, input logic [607:0] h);
        return {n, h};
    endfunction

    function automatic logic [607:0] rnd_hdr();
        logic [607:0] h;
        for (int i = 0; i < 19; i++) h[32*i +: 32] = $urandom;
        return h;
    endfunction

    // Scoreboard: every write must match the oldest queued word, at its expected cycle.
    always @(negedge clk) begin
        if (lq)  chk("write_on_load", {639'b0, write}, 640'd0);
        if (lq1) chk("write1_on_load", {639'b0, write1}, 640'd0);
        if (write === 1'b1) begin
            ntests++;
            assert (q.size() > 0) else begin
                nfail++;
                $error("FAIL unexpected_write: got nonce %h expected none", out[639:608]);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("word", out, e.word);
                chk("cycle", 640'(cyc), 640'(e.at));
            end
        end
        if (write1 === 1'b1) begin
            ntests++;
            assert (q1.size() > 0) else begin
                nfail++;
                $error("FAIL unexpected_write1: got nonce %h expected none", out1[639:608]);
            end
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("word1", out1, e1.word);
                chk("cycle1", 640'(cyc), 640'(e1.at));
            end
        end
    end

    task automatic do_load(input logic [607:0] h, input logic [31:0] s, input logic [31:0] en,
                           input bit use1, output int le);
        @(negedge clk);
        header_in   = h;
        nonce_start = s;
        nonce_end   = en;
        if (use1) load1 = 1'b1;
        else      load  = 1'b1;
        le = cyc + 1;
        @(negedge clk);
        load  = 1'b0;
        load1 = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] n, input logic [607:0] h, input int at);
        exp_t x;
        x.word = w(n, h);
        x.at   = at;
        q.push_back(x);
    endtask

    initial begin
        logic [607:0] h1, h2, h3, h4, h5, h6;
        int le, le2, w1;

        for (int i = 0; i < 76; i++) h1[8*i +: 8] = 8'(i + 1);
        h2 = rnd_hdr(); h3 = rnd_hdr(); h4 = rnd_hdr(); h5 = rnd_hdr(); h6 = rnd_hdr();

        // Reset state
        #3;
        chk("rst_out", out, 640'd0);
        chk("rst_write", {639'b0, write}, 640'd0);
        chk("rst_busy", {639'b0, busy}, 640'd0);
        chk("rst_done", {639'b0, done}, 640'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic range 5..7, THROUGHPUT 10
        do_load(h1, 32'd5, 32'd7, 1'b0, le);
        push(32'd5, h1, le + 1);
        push(32'd6, h1, le + 11);
        push(32'd7, h1, le + 21);
        wait_until(le + 1);
        chk("t1_busy_run", {639'b0, busy}, 640'd1);
        chk("t1_done_run", {639'b0, done}, 640'd0);
        wait_until(le + 21);
        chk("t1_busy_end", {639'b0, busy}, 640'd0);
        chk("t1_done_end", {639'b0, done}, 640'd1);
        wait_until(le + 25);
        chk("t1_drained", 640'(q.size()), 640'd0);

        // Single-word range
        do_load(h2, 32'hABCD0000, 32'hABCD0000, 1'b0, le);
        push(32'hABCD0000, h2, le + 1);
        wait_until(le + 51);
        chk("t2_done", {639'b0, done}, 640'd1);
        chk("t2_drained", 640'(q.size()), 640'd0);

        // Wrapping range on the THROUGHPUT=1 instance
        do_load(h3, 32'hFFFFFFFE, 32'd1, 1'b1, le);
        for (int i = 0; i < 4; i++) begin
            exp_t x;
            x.word = w(32'hFFFFFFFE + 32'(i), h3);
            x.at   = le + 1 + i;
            q1.push_back(x);
        end
        wait_until(le + 6);
        chk("t3_done1", {639'b0, done1}, 640'd1);
        chk("t3_drained", 640'(q1.size()), 640'd0);

        // Pause deferral
        do_load(h4, 32'd0, 32'd9, 1'b0, le);
        w1 = le + 11;
        push(32'd0, h4, le + 1);
        push(32'd1, h4, w1);
        for (int k = 2; k < 10; k++) push(32'(k), h4, w1 + 28 + 10 * (k - 2));
        wait_until(w1 + 2);
        pause = 1'b1;
        repeat (25) @(negedge clk);
        pause = 1'b0;
        wait_until(w1 + 28 + 70 + 3);
        chk("t4_done", {639'b0, done}, 640'd1);
        chk("t4_drained", 640'(q.size()), 640'd0);

        // Mid-range abort by a new load
        do_load(h5, 32'd0, 32'd9, 1'b0, le);
        for (int i = 0; i < 4; i++) push(32'(i), h5, le + 1 + 10 * i);
        wait_until(le + 33);
        do_load(h6, 32'd100, 32'd101, 1'b0, le2);
        push(32'd100, h6, le2 + 1);
        push(32'd101, h6, le2 + 11);
        wait_until(le2 + 30);
        chk("t5_done", {639'b0, done}, 640'd1);
        chk("t5_drained", 640'(q.size()), 640'd0);

        // Asynchronous reset while a write is on the output
        do_load(h1, 32'd0, 32'd9, 1'b0, le);
        push(32'd0, h1, le + 1);
        wait_until(le + 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_write", {639'b0, write}, 640'd0);
        chk("t6_busy", {639'b0, busy}, 640'd0);
        chk("t6_out", out, 640'd0);
        #1 reset = 1'b0;
        wait_until(le + 31);
        chk("t6_idle_busy", {639'b0, busy}, 640'd0);
        chk("t6_idle_done", {639'b0, done}, 640'd0);
        chk("t6_drained", 640'(q.size()), 640'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
